selection_type_de: RTL and testbench

Die-type selector feeding the "dN" display stage. Two push-buttons step through the supported die types (d4, d6, d8, d10, d12, d20, d100). The block debounces both buttons and holds the current face count. An iterative binary-to-BCD converter produces the hundreds/tens/units digits and the leading-zero blanking enables consumed by the type display. The binary face count also goes to the roll generator.

---
 rtl/selection_type_de_if.sv | 29 ++
 rtl/selection_type_de.sv | 204 ++++++++++++++++++++
 tb/tb_selection_type_de.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/selection_type_de_if.sv
// Bundle for the die-type selector: raw keys in, face count and its BCD
// display digits out. conv_state exposes the converter FSM state for debug.
//
// Handshake: valid is a level, high whenever bcd100/bcd10/bcd1/en100/en10
// correspond to faces; changed pulses for exactly one cycle on the edge new
// digits are committed. There is no ready: consumers sample, they never stall.
interface selection_type_de_if;
  logic       btn_next;
  logic       btn_prev;
  logic [6:0] faces;
  logic [3:0] bcd100;
  logic [3:0] bcd10;
  logic [3:0] bcd1;
  logic       en100;
  logic       en10;
  logic       valid;
  logic       changed;
  logic [1:0] conv_state;

  modport master (
    input  btn_next, btn_prev,
    output faces, bcd100, bcd10, bcd1, en100, en10, valid, changed, conv_state
  );

  modport slave (
    output btn_next, btn_prev,
    input  faces, bcd100, bcd10, bcd1, en100, en10, valid, changed, conv_state
  );
endinterface

// File: rtl/selection_type_de.sv
// Die-type selector: synchronises and debounces two active-low keys, steps a
// die index through d4..d100 and converts the face count to BCD digits with a
// serial double-dabble converter (one bit per cycle).
module selection_type_de #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = 19
) (
  input  logic                 clk,
  input  logic                 rst_n,
  selection_type_de_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

  // bit 0 = next key, bit 1 = prev key
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0][DEB_W-1:0] cnt_q, cnt_d;
  logic [1:0]            press;

  logic [2:0]  index_q, index_d;
  logic [6:0]  faces_q, faces_d;
  logic        start_q, start_d;

  state_t      state_q, state_d;
  logic [6:0]  shift_q, shift_d;
  logic [11:0] acc_q, acc_d, adj;
  logic [2:0]  iter_q, iter_d;
  logic [3:0]  bcd100_q, bcd100_d, bcd10_q, bcd10_d, bcd1_q, bcd1_d;
  logic        en100_q, en100_d, en10_q, en10_d;
  logic        valid_q, valid_d, changed_q, changed_d;

  function automatic logic [6:0] face_of(input logic [2:0] idx);
    case (idx)
      3'd0:    face_of = 7'd4;
      3'd1:    face_of = 7'd6;
      3'd2:    face_of = 7'd8;
      3'd3:    face_of = 7'd10;
      3'd4:    face_of = 7'd12;
      3'd5:    face_of = 7'd20;
      3'd6:    face_of = 7'd100;
      default: face_of = 7'd4;
    endcase
  endfunction

  // Two-stage synchronisers; idle level is released (1).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {bus.btn_prev, bus.btn_next};
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept the synchronised level once it has differed for the full window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
    // A press is the debounced level falling on this edge; releases are ignored.
    press = deb_q & ~deb_d;
  end

  // Index stepping with wrap; simultaneous presses cancel out.
  always_comb begin
    index_d = index_q;
    start_d = 1'b0;
    case (press)
      2'b01: begin
        index_d = (index_q == 3'd6) ? 3'd0 : index_q + 3'd1;
        start_d = 1'b1;
      end
      2'b10: begin
        index_d = (index_q == 3'd0) ? 3'd6 : index_q - 3'd1;
        start_d = 1'b1;
      end
      default: ;
    endcase
    faces_d = face_of(index_d);
  end

  // Converter next state: a pending start always wins, so a new selection
  // during CONV or DONE restarts the conversion and suppresses the commit.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    acc_d     = acc_q;
    iter_d    = iter_q;
    bcd100_d  = bcd100_q;
    bcd10_d   = bcd10_q;
    bcd1_d    = bcd1_q;
    en100_d   = en100_q;
    en10_d    = en10_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    adj       = acc_q;
    if (start_q) begin
      shift_d = faces_q;
      acc_d   = '0;
      iter_d  = '0;
      valid_d = 1'b0;
      state_d = S_CONV;
    end else begin
      case (state_q)
        S_CONV: begin
          for (int k = 0; k < 3; k++) begin
            if (acc_q[k*4 +: 4] >= 4'd5) adj[k*4 +: 4] = acc_q[k*4 +: 4] + 4'd3;
          end
          acc_d   = {adj[10:0], shift_q[6]};
          shift_d = {shift_q[5:0], 1'b0};
          iter_d  = iter_q + 3'd1;
          if (iter_q == 3'd6) state_d = S_DONE;
        end
        S_DONE: begin
          bcd100_d  = acc_q[11:8];
          bcd10_d   = acc_q[7:4];
          bcd1_d    = acc_q[3:0];
          en100_d   = (acc_q[11:8] != 4'd0);
          en10_d    = (acc_q[11:8] != 4'd0) || (acc_q[7:4] != 4'd0);
          valid_d   = 1'b1;
          changed_d = 1'b1;
          state_d   = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  // Debouncer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 2'b11;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  // Selection and converter registers; reset shows d6 already converted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q   <= 3'd1;
      faces_q   <= 7'd6;
      start_q   <= 1'b0;
      state_q   <= S_IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      iter_q    <= '0;
      bcd100_q  <= 4'd0;
      bcd10_q   <= 4'd0;
      bcd1_q    <= 4'd6;
      en100_q   <= 1'b0;
      en10_q    <= 1'b0;
      valid_q   <= 1'b1;
      changed_q <= 1'b0;
    end else begin
      index_q   <= index_d;
      faces_q   <= faces_d;
      start_q   <= start_d;
      state_q   <= state_d;
      shift_q   <= shift_d;
      acc_q     <= acc_d;
      iter_q    <= iter_d;
      bcd100_q  <= bcd100_d;
      bcd10_q   <= bcd10_d;
      bcd1_q    <= bcd1_d;
      en100_q   <= en100_d;
      en10_q    <= en10_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign bus.faces      = faces_q;
  assign bus.bcd100     = bcd100_q;
  assign bus.bcd10      = bcd10_q;
  assign bus.bcd1       = bcd1_q;
  assign bus.en100      = en100_q;
  assign bus.en10       = en10_q;
  assign bus.valid      = valid_q;
  assign bus.changed    = changed_q;
  assign bus.conv_state = state_q;

endmodule

// File: tb/tb_selection_type_de.sv
// Bench for selection_type_de with a short debounce window. A behavioural
// model predicts every output from the key timeline; a compare process checks
// it each cycle, and directed scenarios pin literal values.
module tb_selection_type_de;
  localparam int D = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  selection_type_de_if bus();

  selection_type_de #(.DEBOUNCE_CYCLES(D), .DEB_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;

  // Scoreboard of expected accepted events: cycle of edge E and step (+1, -1, 0 = both).
  int ev_cyc[$];
  int ev_kind[$];

  // Model state
  int m_idx, m_faces, m_d100, m_d10, m_d1;
  int m_en100, m_en10, m_valid, m_changed;
  int busy_at, commit_at;

  function automatic int face_tbl(input int i);
    case (i)
      0: return 4;
      1: return 6;
      2: return 8;
      3: return 10;
      4: return 12;
      5: return 20;
      default: return 100;
    endcase
  endfunction

  function automatic void model_reset();
    m_idx = 1; m_faces = 6;
    m_d100 = 0; m_d10 = 0; m_d1 = 6;
    m_en100 = 0; m_en10 = 0; m_valid = 1; m_changed = 0;
    busy_at = -1; commit_at = -1;
    ev_cyc.delete();
    ev_kind.delete();
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Behavioural model: an accepted event changes the selection at E, hides the
  // digits from E+1 and commits decimal digits of the face count at E+9.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        cyc++;
        m_changed = 0;
        if (cyc == busy_at) m_valid = 0;
        if (cyc == commit_at) begin
          m_d100  = m_faces / 100;
          m_d10   = (m_faces / 10) % 10;
          m_d1    = m_faces % 10;
          m_en100 = (m_d100 != 0) ? 1 : 0;
          m_en10  = (m_d100 != 0 || m_d10 != 0) ? 1 : 0;
          m_valid = 1;
          m_changed = 1;
        end
        while (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
          int kind;
          kind = ev_kind.pop_front();
          void'(ev_cyc.pop_front());
          if (kind != 0) begin
            m_idx     = (m_idx + kind + 7) % 7;
            m_faces   = face_tbl(m_idx);
            busy_at   = cyc + 1;
            commit_at = cyc + 9;
          end
        end
      end
    end
  end

  // Compare process, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.changed) pulses++;
      chk("cmp_faces",   int'(bus.faces),   m_faces);
      chk("cmp_bcd100",  int'(bus.bcd100),  m_d100);
      chk("cmp_bcd10",   int'(bus.bcd10),   m_d10);
      chk("cmp_bcd1",    int'(bus.bcd1),    m_d1);
      chk("cmp_en100",   int'(bus.en100),   m_en100);
      chk("cmp_en10",    int'(bus.en10),    m_en10);
      chk("cmp_valid",   int'(bus.valid),   m_valid);
      chk("cmp_changed", int'(bus.changed), m_changed);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic key_down(input bit nxt, input bit prv);
    if (nxt) bus.btn_next = 1'b0;
    if (prv) bus.btn_prev = 1'b0;
    ev_cyc.push_back(cyc + 2 + D);
    ev_kind.push_back((nxt && prv) ? 0 : (nxt ? 1 : -1));
  endtask

  task automatic key_up();
    bus.btn_next = 1'b1;
    bus.btn_prev = 1'b1;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit nxt, input bit prv);
    key_down(nxt, prv);
    wait_neg(D + 4);
    key_up();
    wait_neg(D + 8);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    wait_neg(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_faces"},   int'(bus.faces),   6);
    chk({tag, "_bcd100"},  int'(bus.bcd100),  0);
    chk({tag, "_bcd10"},   int'(bus.bcd10),   0);
    chk({tag, "_bcd1"},    int'(bus.bcd1),    6);
    chk({tag, "_en100"},   int'(bus.en100),   0);
    chk({tag, "_en10"},    int'(bus.en10),    0);
    chk({tag, "_valid"},   int'(bus.valid),   1);
    chk({tag, "_changed"}, int'(bus.changed), 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int p0;
    bus.btn_next = 1'b1;
    bus.btn_prev = 1'b1;
    wait_neg(3);
    chk_reset_vals("rst");
    #2 rst_n = 1'b1;
    @(negedge clk);

    // One next press with explicit E-relative timing.
    p0 = pulses;
    key_down(1'b1, 1'b0);
    wait_neg(2 + D);
    chk("e0_faces", int'(bus.faces), 8);
    chk("e0_valid", int'(bus.valid), 1);
    wait_neg(1);
    chk("e1_valid", int'(bus.valid), 0);
    wait_neg(7);
    chk("e8_valid",   int'(bus.valid),   0);
    chk("e8_changed", int'(bus.changed), 0);
    wait_neg(1);
    chk("e9_valid",   int'(bus.valid),   1);
    chk("e9_changed", int'(bus.changed), 1);
    chk("e9_bcd1",    int'(bus.bcd1),    8);
    chk("e9_en10",    int'(bus.en10),    0);
    wait_neg(1);
    chk("e10_changed", int'(bus.changed), 0);
    key_up();
    wait_neg(D + 8);
    chk("next1_pulses", pulses - p0, 1);

    // Step up to d100, then wrap to d4.
    repeat (4) press(1'b1, 1'b0);
    chk("d100_faces",  int'(bus.faces),  100);
    chk("d100_bcd100", int'(bus.bcd100), 1);
    chk("d100_bcd10",  int'(bus.bcd10),  0);
    chk("d100_bcd1",   int'(bus.bcd1),   0);
    chk("d100_en100",  int'(bus.en100),  1);
    chk("d100_en10",   int'(bus.en10),   1);
    press(1'b1, 1'b0);
    chk("wrap_faces", int'(bus.faces), 4);
    chk("wrap_bcd1",  int'(bus.bcd1),  4);
    chk("wrap_en100", int'(bus.en100), 0);
    chk("wrap_en10",  int'(bus.en10),  0);

    // Prev from reset: d4, then wrap to d100; then a short glitch.
    do_reset();
    press(1'b0, 1'b1);
    chk("prev1_faces", int'(bus.faces), 4);
    press(1'b0, 1'b1);
    chk("prev2_faces", int'(bus.faces), 100);
    chk("prev2_en10",  int'(bus.en10),  1);
    p0 = pulses;
    bus.btn_prev = 1'b0;
    wait_neg(2);
    bus.btn_prev = 1'b1;
    wait_neg(D + 8);
    chk("glitch_faces",  int'(bus.faces), 100);
    chk("glitch_pulses", pulses - p0, 0);

    // From d12: next then prev accepted 3 cycles later, mid-conversion.
    do_reset();
    repeat (3) press(1'b1, 1'b0);
    chk("d12_faces", int'(bus.faces), 12);
    p0 = pulses;
    key_down(1'b1, 1'b0);
    wait_neg(3);
    key_down(1'b0, 1'b1);
    wait_neg(3);
    chk("mid_faces20", int'(bus.faces), 20);
    wait_neg(5);
    bus.btn_next = 1'b1;
    wait_neg(3);
    bus.btn_prev = 1'b1;
    wait_neg(D + 10);
    chk("mid_faces12", int'(bus.faces),  12);
    chk("mid_pulses",  pulses - p0,      1);
    chk("mid_bcd10",   int'(bus.bcd10),  1);
    chk("mid_bcd1",    int'(bus.bcd1),   2);
    chk("mid_bcd100",  int'(bus.bcd100), 0);

    // Both keys accepted on the same edge: nothing happens.
    p0 = pulses;
    press(1'b1, 1'b1);
    chk("both_faces",  int'(bus.faces), 12);
    chk("both_valid",  int'(bus.valid), 1);
    chk("both_pulses", pulses - p0, 0);

    // Reset in the middle of a conversion.
    do_reset();
    p0 = pulses;
    key_down(1'b1, 1'b0);
    wait_neg(2 + D + 3);
    chk("conv_valid", int'(bus.valid), 0);
    chk("conv_faces", int'(bus.faces), 8);
    key_up();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    wait_neg(3);
    #2 rst_n = 1'b1;
    wait_neg(D + 12);
    chk_reset_vals("post");
    chk("arst_pulses", pulses - p0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
